// File: rtl/mvm_sequencer.sv
// Matrix-vector multiply sequencer: issues the per-row buffer read bursts, waits for
// the PE pipeline to drain, then writes each row result, with PE accumulate/clear strobes.

`ifndef MEM0_ADDR_WIDTH
`define MEM0_ADDR_WIDTH 8
`endif
`ifndef BUF_MEMB_OFFSET_BITWIDTH
`define BUF_MEMB_OFFSET_BITWIDTH 6
`endif
`ifndef BUF_READ
`define BUF_READ 2'd1
`endif
`ifndef BUF_WRITE
`define BUF_WRITE 2'd2
`endif

package mvm_sequencer_pkg;
    localparam int BUF_MA_W   = `MEM0_ADDR_WIDTH;
    localparam int BUF_MB_W   = `BUF_MEMB_OFFSET_BITWIDTH;
    localparam int BUF_OP_W   = 2;
    localparam int BUF_MODE_W = 2;

    localparam logic [BUF_OP_W-1:0] BUF_OP_READ  = `BUF_READ;
    localparam logic [BUF_OP_W-1:0] BUF_OP_WRITE = `BUF_WRITE;

    typedef struct packed {
        logic [BUF_OP_W-1:0]   opcode;
        logic [BUF_MODE_W-1:0] mode;
        logic [BUF_MA_W-1:0]   mema_offset;
        logic [BUF_MB_W-1:0]   memb_offset;
    } buf_inst_t;
endpackage

// state | meaning
// IDLE  | waiting for start; inputs latched on start
// READ  | one matrix/vector read per cycle, k = 0..K-1
// DRAIN | PE_LATENCY cycles for the PE pipeline to produce the row result
// WRITE | one write of the row result to out_base + r
// FIN   | one-cycle done pulse, then back to IDLE
module mvm_sequencer
    import mvm_sequencer_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int PE_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      num_rows_i,
    input  logic [CNT_W-1:0]      num_cols_i,
    input  logic [BUF_MA_W-1:0]   mema_base_i,
    input  logic [BUF_MB_W-1:0]   memb_base_i,
    input  logic [BUF_MA_W-1:0]   out_base_i,
    input  logic [BUF_MODE_W-1:0] mode_i,
    output buf_inst_t             buf_inst_o,
    output logic                  buf_inst_valid_o,
    output logic                  pe_acc_en_o,
    output logic                  pe_clear_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int DW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(PE_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      r_q, r_d, k_q, k_d;
    logic [CNT_W-1:0]      rows_q, rows_d, cols_q, cols_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  empty_q, empty_d;
    logic [BUF_MA_W-1:0]   mema_base_q, mema_base_d, out_base_q, out_base_d;
    logic [BUF_MB_W-1:0]   memb_base_q, memb_base_d;
    logic [BUF_MODE_W-1:0] mode_q, mode_d;
    logic [2*CNT_W-1:0]    prod;
    buf_inst_t             inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  acc_q, clear_q, busy_q, done_q;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        k_d         = k_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        drain_d     = drain_q;
        empty_d     = empty_q;
        mema_base_d = mema_base_q;
        memb_base_d = memb_base_q;
        out_base_d  = out_base_q;
        mode_d      = mode_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rows_d      = num_rows_i;
                    cols_d      = num_cols_i;
                    mema_base_d = mema_base_i;
                    memb_base_d = memb_base_i;
                    out_base_d  = out_base_i;
                    mode_d      = mode_i;
                    r_d         = '0;
                    k_d         = '0;
                    // Empty runs spend one busy cycle in DRAIN so done lands two cycles after start
                    if (num_rows_i == '0 || num_cols_i == '0) begin
                        empty_d = 1'b1;
                        drain_d = '0;
                        state_d = DRAIN;
                    end else begin
                        empty_d = 1'b0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (k_q == cols_q - CNT_W'(1)) begin
                    k_d     = '0;
                    drain_d = DRAIN_LOAD;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (empty_q) begin
                    state_d = FIN;
                end else if (drain_q == '0) begin
                    state_d = WRITE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            WRITE: begin
                if (r_q == rows_q - CNT_W'(1)) begin
                    state_d = FIN;
                end else begin
                    r_d     = r_q + CNT_W'(1);
                    state_d = READ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Instruction fields are built from next-state values so the registered output
    // appears in the same cycle the state register enters READ/WRITE.
    always_comb begin
        inst_d  = '0;
        valid_d = 1'b0;
        prod    = {{CNT_W{1'b0}}, r_d} * {{CNT_W{1'b0}}, cols_d};
        if (state_d == READ) begin
            valid_d            = 1'b1;
            inst_d.opcode      = BUF_OP_READ;
            inst_d.mode        = mode_d;
            inst_d.mema_offset = mema_base_d + BUF_MA_W'(prod) + BUF_MA_W'(k_d);
            inst_d.memb_offset = memb_base_d + BUF_MB_W'(k_d);
        end else if (state_d == WRITE) begin
            valid_d            = 1'b1;
            inst_d.opcode      = BUF_OP_WRITE;
            inst_d.mode        = mode_d;
            inst_d.mema_offset = out_base_d + BUF_MA_W'(r_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            k_q         <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            drain_q     <= '0;
            empty_q     <= 1'b0;
            mema_base_q <= '0;
            memb_base_q <= '0;
            out_base_q  <= '0;
            mode_q      <= '0;
            inst_q      <= '0;
            valid_q     <= 1'b0;
            acc_q       <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            k_q         <= k_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            drain_q     <= drain_d;
            empty_q     <= empty_d;
            mema_base_q <= mema_base_d;
            memb_base_q <= memb_base_d;
            out_base_q  <= out_base_d;
            mode_q      <= mode_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            acc_q       <= (state_q == READ);
            clear_q     <= (state_q == READ) && (k_q == '0);
            busy_q      <= (state_d == READ) || (state_d == DRAIN) || (state_d == WRITE);
            done_q      <= (state_d == FIN);
        end
    end

    assign buf_inst_o       = inst_q;
    assign buf_inst_valid_o = valid_q;
    assign pe_acc_en_o      = acc_q;
    assign pe_clear_o       = clear_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Scoreboard bench for mvm_sequencer: runs push expected instructions/done pulses with
// their cycle offset from start; a negedge monitor pops and compares them.
module tb_mvm_sequencer;
    import mvm_sequencer_pkg::*;

    localparam int CNT_W = 8;
    localparam int PE_L  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_i = 1'b0;
    logic [CNT_W-1:0]      num_rows_i = '0;
    logic [CNT_W-1:0]      num_cols_i = '0;
    logic [BUF_MA_W-1:0]   mema_base_i = '0;
    logic [BUF_MB_W-1:0]   memb_base_i = '0;
    logic [BUF_MA_W-1:0]   out_base_i = '0;
    logic [BUF_MODE_W-1:0] mode_i = '0;
    buf_inst_t             buf_inst_o;
    logic                  buf_inst_valid_o, pe_acc_en_o, pe_clear_o, busy_o, done_o;

    mvm_sequencer #(.CNT_W(CNT_W), .PE_LATENCY(PE_L)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .num_rows_i(num_rows_i), .num_cols_i(num_cols_i),
        .mema_base_i(mema_base_i), .memb_base_i(memb_base_i), .out_base_i(out_base_i),
        .mode_i(mode_i), .buf_inst_o(buf_inst_o), .buf_inst_valid_o(buf_inst_valid_o),
        .pe_acc_en_o(pe_acc_en_o), .pe_clear_o(pe_clear_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    kind;   // 0 instruction, 1 done pulse
        logic [BUF_OP_W-1:0]   op;
        logic [BUF_MA_W-1:0]   ma;
        logic [BUF_MB_W-1:0]   mb;
        logic [BUF_MODE_W-1:0] md;
        int                    t;
        bit                    first;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   acc_exp = 1'b0;
    bit   clr_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_inst(input logic [BUF_OP_W-1:0] op, input int ma, input int mb,
                             input int md, input int t, input bit first);
        exp_t e;
        e.kind = 0; e.op = op; e.ma = BUF_MA_W'(ma); e.mb = BUF_MB_W'(mb);
        e.md = BUF_MODE_W'(md); e.t = t; e.first = first;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int t);
        exp_t e;
        e.kind = 1; e.op = '0; e.ma = '0; e.mb = '0; e.md = '0; e.t = t; e.first = 1'b0;
        exp_q.push_back(e);
    endtask

    // Expected stream: row r reads at 1+r*(K+L+1)+k, write at 1+r*(K+L+1)+K+L, done at R*(K+L+1)+1.
    task automatic push_run(input int R, input int K, input int ma, input int mb,
                            input int ob, input int md);
        int per;
        per = K + PE_L + 1;
        if (R == 0 || K == 0) begin
            push_done(2);
            return;
        end
        for (int r = 0; r < R; r++) begin
            for (int k = 0; k < K; k++)
                push_inst(BUF_OP_READ, ma + r*K + k, mb + k, md, 1 + r*per + k, k == 0);
            push_inst(BUF_OP_WRITE, ob + r, 0, md, 1 + r*per + K + PE_L, 1'b0);
        end
        push_done(R*per + 1);
    endtask

    task automatic do_start(input int R, input int K, input int ma, input int mb,
                            input int ob, input int md);
        @(negedge clk);
        num_rows_i = CNT_W'(R); num_cols_i = CNT_W'(K);
        mema_base_i = BUF_MA_W'(ma); memb_base_i = BUF_MB_W'(mb);
        out_base_i = BUF_MA_W'(ob); mode_i = BUF_MODE_W'(md);
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic check1(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check1({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check1({name, "_busy_after"}, int'(busy_o), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_exp = 1'b0;
            clr_exp = 1'b0;
        end else begin
            int rel;
            rel = cyc - t0;
            checks++;
            if (pe_acc_en_o !== acc_exp || pe_clear_o !== clr_exp) begin
                errors++;
                $display("FAIL pe_strobes rel=%0d acc=%b clr=%b expected acc=%b clr=%b",
                         rel, pe_acc_en_o, pe_clear_o, acc_exp, clr_exp);
            end
            acc_exp = 1'b0;
            clr_exp = 1'b0;
            if (buf_inst_valid_o) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != 0) begin
                    errors++;
                    $display("FAIL unexpected_inst rel=%0d op=%0d mema=%0h", rel,
                             buf_inst_o.opcode, buf_inst_o.mema_offset);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (buf_inst_o.opcode !== e.op || buf_inst_o.mema_offset !== e.ma ||
                        buf_inst_o.memb_offset !== e.mb || buf_inst_o.mode !== e.md || rel != e.t) begin
                        errors++;
                        $display("FAIL inst rel=%0d op=%0d mema=%0h memb=%0h mode=%0d expected rel=%0d op=%0d mema=%0h memb=%0h mode=%0d",
                                 rel, buf_inst_o.opcode, buf_inst_o.mema_offset, buf_inst_o.memb_offset,
                                 buf_inst_o.mode, e.t, e.op, e.ma, e.mb, e.md);
                    end
                    if (e.op == BUF_OP_READ) begin
                        acc_exp = 1'b1;
                        clr_exp = e.first;
                    end
                end
            end else if (buf_inst_o !== '0) begin
                checks++;
                errors++;
                $display("FAIL idle_fields rel=%0d inst=%0h expected 0", rel, buf_inst_o);
            end
            if (done_o) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
                    errors++;
                    $display("FAIL unexpected_done rel=%0d", rel);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rel != e.t || busy_o !== 1'b0) begin
                        errors++;
                        $display("FAIL done rel=%0d busy=%b expected rel=%0d busy=0", rel, busy_o, e.t);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check1("rst_valid", int'(buf_inst_valid_o), 0);
        check1("rst_inst", int'(buf_inst_o), 0);
        check1("rst_acc_clr", int'({pe_acc_en_o, pe_clear_o}), 0);
        check1("rst_busy_done", int'({busy_o, done_o}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // R=2 K=3: reads 0x10..0x15, writes 0x40/0x41 at rel 7/14, done at 15
        push_run(2, 3, 'h10, 0, 'h40, 1);
        do_start(2, 3, 'h10, 0, 'h40, 1);
        check1("run1_busy_rel1", int'(busy_o), 1);
        wait_drained("run1");

        // Empty run: one busy cycle, done at rel 2, no instruction
        push_run(0, 5, 'h10, 0, 'h40, 0);
        do_start(0, 5, 'h10, 0, 'h40, 0);
        check1("empty_busy_rel1", int'(busy_o), 1);
        @(negedge clk);
        check1("empty_busy_rel2", int'(busy_o), 0);
        wait_drained("empty");

        // Address wrap: mema FE,FF,00,01 and memb 3E,3F,00,01
        push_run(1, 4, 'hFE, 'h3E, 'hFF, 2);
        do_start(1, 4, 'hFE, 'h3E, 'hFF, 2);
        wait_drained("wrap");

        // K=1 boundary: every read is the first beat of its row
        push_run(3, 1, 'h00, 'h07, 'hF0, 3);
        do_start(3, 1, 'h00, 'h07, 'hF0, 3);
        wait_drained("k1");

        // Second start during DRAIN with different inputs is ignored
        push_run(1, 2, 'h30, 'h05, 'h80, 2);
        do_start(1, 2, 'h30, 'h05, 'h80, 2);
        @(negedge clk);
        @(negedge clk);
        num_rows_i = 8'd5; num_cols_i = 8'd7; mema_base_i = 'h99;
        out_base_i = 'h11; mode_i = 2'd0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_drained("restart");

        // Reset during DRAIN of row 0: only the two reads come out, no write, no done
        push_inst(BUF_OP_READ, 'h20, 'h00, 1, 1, 1'b1);
        push_inst(BUF_OP_READ, 'h21, 'h01, 1, 2, 1'b0);
        do_start(2, 2, 'h20, 'h00, 'h60, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("arst_valid", int'(buf_inst_valid_o), 0);
        check1("arst_acc_clr", int'({pe_acc_en_o, pe_clear_o}), 0);
        check1("arst_busy_done", int'({busy_o, done_o}), 0);
        check1("arst_reads_seen", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_run(1, 2, 'h50, 'h02, 'h70, 1);
        do_start(1, 2, 'h50, 'h02, 'h70, 1);
        wait_drained("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
